keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Drives the row lines of a 4x4 matrix keypad and samples the column lines. Debounces presses and releases, and encodes the pressed key as a 4-bit hex code. Emits a one-cycle new-key strobe that feeds the two-digit display shift register (enable of the current/previous digit flops). One key is registered per physical press; there is no rollover and no auto-repeat.

Parameters:
SETTLE_CYCLES, 64, clk cycles each row is driven before cols are sampled (covers 2-flop sync plus line settling)
DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a press or a release
CNT_WIDTH, $clog2(DEBOUNCE_CYCLES+1), width of the shared dwell/debounce counter (must also hold SETTLE_CYCLES)

Ports:
clk        input   1  system clock (HSOSC-derived)
reset      input   1  asynchronous, active-low reset
cols       input   4  raw keypad columns, active-low (pulled up; 0 = pressed in the driven row)
rows       output  4  keypad rows, one-cold active-low (0 = row driven)
key_code   output  4  hex code of the last accepted key, held until the next accepted key
key_valid  output  1  one-cycle pulse when key_code is updated
key_held   output  1  high from acceptance until the release debounce completes

Behaviour:
- Reset values (async, reset=0): rows=4'b1110 (row 0), key_code=4'h0, key_valid=0, key_held=0, state=SCAN, counter=0, row index=0, internal 2-flop cols synchronizer=4'b1111.
- All cols decisions use the synchronized value (cs). Raw cols are never used combinationally.
- Key map [row][col], where col 0 = cols[0]: row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: E 0 F D.
- SCAN: drive the current row low and count to SETTLE_CYCLES-1.
  - At the terminal count, sample cs.
  - Exactly one bit low: latch row/col, clear counter, go to DEBOUNCE.
  - All bits high, or more than one bit low: advance the row index (3 wraps to 0), clear counter, stay in SCAN.
- DEBOUNCE: row stays driven.
  - Each cycle cs must equal the latched one-cold pattern. Any mismatch: clear counter, return to SCAN on the same row.
  - After DEBOUNCE_CYCLES consecutive matches: update key_code, pulse key_valid for exactly 1 cycle, set key_held=1, go to HELD.
- HELD: row stays driven.
  - While the latched col bit is low, stay. Presses of other cols or rows are ignored.
  - When cs==4'b1111: clear counter, go to RELEASE.
- RELEASE: each cycle with cs==4'b1111 increments the counter.
  - Any bit low: go back to HELD with no new key_valid.
  - After DEBOUNCE_CYCLES all-high cycles: key_held=0, advance row, clear counter, go to SCAN.
- Latency: a clean press in the driven row produces key_valid DEBOUNCE_CYCLES+1 cycles after the SCAN sample (±1). Worst case from press onset adds 4*SETTLE_CYCLES.
- key_valid is never high on two consecutive cycles. key_code changes only in the key_valid cycle.
- rows is always exactly one-cold, including during reset.
- Reset asserted mid-operation returns everything to reset values immediately. After release, scanning restarts at row 0, and a key still held is accepted once as a new press.
- The counter saturates and never wraps.

Test Plan:
Use SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8, and a keypad model that pulls col c low when row r is low and key (r,c) is pressed.
- Reset: hold reset=0 with key 5 pressed -> rows=1110, key_code=0, key_valid=0, key_held=0 throughout. After release, scanning cycles rows 1110→1101→1011→0111→1110 every 4 cycles.
- Clean press of key 6 (row1, col2) for 40 cycles -> exactly one key_valid pulse with key_code=4'h6. key_held=1 until 8 cycles after the keypad model releases.
- Bounce: toggle key 9 every 3 cycles for 30 cycles, then hold it stable -> no key_valid during bounce, then one pulse with key_code=4'h9. Release with a 5-cycle bounce -> no second pulse.
- Held rollover: press D (row3, col3), then press 1 while D is held, then release D -> key_code stays 4'hD and no pulse occurs for 1 until it is re-detected in SCAN after release debounce.
- Multi-key: press 2 and 3 (same row) simultaneously -> no key_valid. Release 3 -> key_code=4'h2 with one pulse.
- Mid-press reset: assert reset during DEBOUNCE of key A -> outputs return to reset values asynchronously. After deassert, with A still held, exactly one pulse with key_code=4'hA.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one-cold rows, debounces press and release
// on the synchronized columns and reports one hex code per physical press.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 64,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST   = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEBOUNCE_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX       = '1;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [1:0]           row_reg, row_next;
  logic [1:0]           col_reg, col_next;
  logic [3:0]           key_code_reg, key_code_next;
  logic                 key_valid_reg, key_valid_next;
  logic                 key_held_reg, key_held_next;
  logic [3:0]           meta_reg, cs_reg;
  logic [3:0]           col_pattern;
  logic [2:0]           low_count;
  logic [1:0]           low_idx;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Two-flop column synchronizer; idles high so reset looks like "no key".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= 4'b1111;
      cs_reg   <= 4'b1111;
    end else begin
      meta_reg <= cols;
      cs_reg   <= meta_reg;
    end
  end

  // Count low columns and remember which one, for the one-cold test in SCAN.
  always_comb begin
    low_count = 3'd0;
    low_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!cs_reg[i]) begin
        low_count = low_count + 3'd1;
        low_idx   = 2'(i);
      end
    end
  end

  assign col_pattern = ~(4'b0001 << col_reg);
  assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= SCAN;
      cnt_reg       <= '0;
      row_reg       <= 2'd0;
      col_reg       <= 2'd0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    case (state_reg)
      SCAN: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next = '0;
          if (low_count == 3'd1) begin
            col_next   = low_idx;
            state_next = DEBOUNCE;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end

      DEBOUNCE: begin
        // A glitch restarts the settle/sample of the same row.
        if (cs_reg != col_pattern) begin
          cnt_next   = '0;
          state_next = SCAN;
        end else if (cnt_reg == DEBOUNCE_LAST) begin
          cnt_next       = '0;
          key_code_next  = key_map(row_reg, col_reg);
          key_valid_next = 1'b1;
          key_held_next  = 1'b1;
          state_next     = HELD;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      HELD: begin
        if (cs_reg == 4'b1111) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        if (cs_reg != 4'b1111) begin
          cnt_next   = '0;
          state_next = HELD;
        end else if (cnt_reg == DEBOUNCE_LAST) begin
          cnt_next      = '0;
          key_held_next = 1'b0;
          row_next      = row_reg + 2'd1;
          state_next    = SCAN;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = SCAN;
      end
    endcase
  end

  assign rows      = ~(4'b0001 << row_reg);
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected key codes,
// an independent monitor pops them on key_valid and polices output invariants.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = 16'h0000;   // index = row*4 + col
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && pressed[r*4 + c]) cols[c] = 1'b0;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d key(s) still pending after %0d cycles, expected 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic wait_unheld(input string name, input int budget);
    int n;
    n = 0;
    while (key_held && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {7'd0, key_held}, 8'd0);
  endtask

  // Monitor: scoreboard pop on key_valid plus per-cycle invariants.
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code = 4'h0;
  initial begin
    forever begin
      @(negedge clk);
      check("rows_one_cold", 8'($countones(~rows)), 8'd1);
      if (!reset) begin
        prev_valid = 1'b0;
        prev_code  = 4'h0;
      end else begin
        if (key_valid) begin
          check("valid_back_to_back", {7'd0, prev_valid}, 8'd0);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_key_valid: got code %0h, expected no pulse (t=%0t)", key_code, $time);
          end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check("key_code", {4'd0, key_code}, {4'd0, e});
            $display("key %0h accepted (expected %0h) t=%0t", key_code, e, $time);
          end
        end else begin
          check("code_stable", {4'd0, key_code}, {4'd0, prev_code});
        end
        prev_valid = key_valid;
        prev_code  = key_code;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_row;
    int k;
    int nb;
    int guard;

    // Reset held with key 5 pressed: outputs pinned to reset values.
    reset   = 1'b0;
    pressed = 16'h0020;
    repeat (8) begin
      @(negedge clk);
      check("reset_rows", {4'd0, rows}, 8'h0E);
      check("reset_code", {4'd0, key_code}, 8'h00);
      check("reset_valid", {7'd0, key_valid}, 8'd0);
      check("reset_held", {7'd0, key_held}, 8'd0);
    end
    pressed = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 20; s++) begin
      #1;
      exp_row = ~(4'b0001 << ((s / SETTLE) % 4));
      check("scan_rows", {4'd0, rows}, {4'd0, exp_row});
      @(negedge clk);
    end

    // Clean press of key 6 for 40 cycles.
    exp_q.push_back(keymap[6]);
    pressed[6] = 1'b1;
    wait_cycles(40);
    wait_drain("press_6", 1);
    check("held_during_6", {7'd0, key_held}, 8'd1);
    pressed = 16'h0000;
    wait_cycles(DEB - 1);
    check("held_after_release_6", {7'd0, key_held}, 8'd1);
    wait_unheld("release_6", 8);
    wait_cycles(10);

    // Bouncing press of key 9, then a bouncing release.
    for (int i = 0; i < 10; i++) begin
      pressed[10] = ~pressed[10];
      wait_cycles(3);
    end
    exp_q.push_back(keymap[10]);
    pressed[10] = 1'b1;
    wait_drain("press_9", 60);
    check("code_9", {4'd0, key_code}, 8'h09);
    for (int i = 0; i < 5; i++) begin
      pressed[10] = ~pressed[10];
      wait_cycles(1);
    end
    pressed = 16'h0000;
    wait_unheld("release_9", 40);
    wait_cycles(20);

    // Rollover: D held, 1 pressed meanwhile, 1 only accepted after D released.
    exp_q.push_back(keymap[15]);
    pressed[15] = 1'b1;
    wait_drain("press_D", 60);
    pressed[0] = 1'b1;
    wait_cycles(30);
    check("rollover_code", {4'd0, key_code}, 8'h0D);
    check("rollover_held", {7'd0, key_held}, 8'd1);
    pressed[15] = 1'b0;
    exp_q.push_back(keymap[0]);
    wait_drain("press_1_after_D", 80);
    pressed = 16'h0000;
    wait_unheld("release_1", 40);
    wait_cycles(10);

    // Two keys in one row: rejected until only one remains.
    pressed[1] = 1'b1;
    pressed[2] = 1'b1;
    wait_cycles(40);
    check("multi_not_held", {7'd0, key_held}, 8'd0);
    pressed[2] = 1'b0;
    exp_q.push_back(keymap[1]);
    wait_drain("press_2", 60);
    pressed = 16'h0000;
    wait_unheld("release_2", 40);

    // Reset during the debounce of key A, then exactly one acceptance.
    guard = 0;
    while (rows == 4'b1110 && guard < 40) begin @(negedge clk); guard++; end
    pressed[3] = 1'b1;
    guard = 0;
    while (rows != 4'b1110 && guard < 40) begin @(negedge clk); guard++; end
    check("reached_row0", {4'd0, rows}, 8'h0E);
    check("code_before_reset", {4'd0, key_code}, 8'h02);
    repeat (SETTLE + 3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset_rows", {4'd0, rows}, 8'h0E);
    check("midreset_code", {4'd0, key_code}, 8'h00);
    check("midreset_valid", {7'd0, key_valid}, 8'd0);
    check("midreset_held", {7'd0, key_held}, 8'd0);
    wait_cycles(3);
    reset = 1'b1;
    exp_q.push_back(keymap[3]);
    wait_drain("press_A_after_reset", 40);
    pressed = 16'h0000;
    wait_unheld("release_A", 40);
    wait_cycles(10);

    // Randomized presses with random bounce on both edges.
    for (int it = 0; it < 12; it++) begin
      k  = int'($urandom_range(15));
      nb = int'($urandom_range(5));
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b1;
        wait_cycles(int'($urandom_range(3, 1)));
        pressed[k] = 1'b0;
        wait_cycles(int'($urandom_range(3, 1)));
      end
      exp_q.push_back(keymap[k]);
      pressed[k] = 1'b1;
      wait_drain("rand_press", 60);
      wait_cycles(int'($urandom_range(15)));
      check("rand_held", {7'd0, key_held}, 8'd1);
      nb = int'($urandom_range(4));
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b0;
        wait_cycles(int'($urandom_range(3, 1)));
        pressed[k] = 1'b1;
        wait_cycles(int'($urandom_range(3, 1)));
      end
      pressed = 16'h0000;
      wait_unheld("rand_release", 40);
      wait_cycles(int'($urandom_range(12)));
    end

    wait_cycles(20);
    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
